vga_stream_checker: RTL and testbench

Avalon-ST video sink that terminates the test-pattern video stream (header beats XRES, YRES, then XRES×YRES pixel beats) and checks framing, header values and ready-latency-1 protocol. It counts good and bad frames, computes a per-frame additive checksum, and throttles the source with a programmable ready pattern. All results are exposed on an Avalon-MM slave. It sits at the end of a video pipeline in bench and bring-up builds, in place of the VGA output.

---
 rtl/vga_stream_checker.sv | 183 ++++++++++++++++++
 tb/tb_vga_stream_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_checker.sv
// vga_stream_checker: Avalon-ST video sink that terminates a test-pattern
// stream (header beats XRES, YRES, then XRES*YRES pixels). It checks framing,
// header values and the ready-latency-1 handshake, counts good and bad frames,
// keeps an additive checksum and throttles the source with a ready pattern.
// Results are exposed on an Avalon-MM slave.
// Ports:
//   clock, clock_areset_n          clock, async active-low reset
//   s_address/s_writedata/s_read/s_write -> s_readdata, s_waitrequest   MM slave
//   st_valid/st_sop/st_eop/st_data -> st_ready   ST sink (ready latency 1)
module vga_stream_checker #(
  parameter int XRES  = 640,
  parameter int YRES  = 480,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clock_areset_n,
  input  logic [3:0]       s_address,
  input  logic [31:0]      s_writedata,
  output logic [31:0]      s_readdata,
  input  logic             s_read,
  input  logic             s_write,
  output logic             s_waitrequest,
  output logic             st_ready,
  input  logic             st_valid,
  input  logic             st_sop,
  input  logic             st_eop,
  input  logic [WIDTH-1:0] st_data
);
  localparam int NPIX = XRES * YRES;
  localparam int CW   = $clog2(NPIX + 1);

  typedef enum logic [1:0] {S_IDLE, S_HDRY, S_PIX, S_DRAIN} state_t;

  state_t           r_state, w_nstate;
  logic             r_en, r_ready, r_rdy_d, r_rl;
  logic [31:0]      r_thr, r_rdata, r_frames, r_errors, r_csum, r_sum;
  logic [4:0]       r_phase, r_cause;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_xres, r_yres;

  logic        w_wr_ctrl, w_clr, w_en_nxt;
  logic [31:0] w_thr_nxt, w_data32, w_sum_n, w_rmux;
  logic [CW-1:0] w_cnt_n;
  logic        w_last, w_hdr_ok;
  logic        w_cap_x, w_cap_y, w_pix_clr, w_pix_acc, w_good, w_err;
  logic [4:0]  w_cause_set;

  assign w_wr_ctrl = s_write && (s_address == 4'h0);
  assign w_clr     = w_wr_ctrl && s_writedata[1];
  // Ready uses the post-write register values so a CTRL/THROTTLE write shows
  // on st_ready in the very next cycle.
  assign w_en_nxt  = w_wr_ctrl ? s_writedata[0] : r_en;
  assign w_thr_nxt = (s_write && (s_address == 4'h6)) ? s_writedata : r_thr;

  assign w_data32  = 32'(st_data);
  assign w_cnt_n   = r_cnt + 1'b1;
  assign w_sum_n   = r_sum + w_data32;
  assign w_last    = (w_cnt_n == CW'(NPIX));
  assign w_hdr_ok  = (32'(r_xres) == 32'(XRES)) && (w_data32 == 32'(YRES));

  assign st_ready      = r_ready;
  assign s_readdata    = r_rdata;
  assign s_waitrequest = s_read & ~r_rl;

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) r_state <= S_IDLE;
    else if (w_clr)      r_state <= S_IDLE;
    else                 r_state <= w_nstate;
  end

  always_comb begin
    w_nstate    = r_state;
    w_cap_x     = 1'b0;
    w_cap_y     = 1'b0;
    w_pix_clr   = 1'b0;
    w_pix_acc   = 1'b0;
    w_good      = 1'b0;
    w_err       = 1'b0;
    w_cause_set = 5'b0;
    if (st_valid) begin
      case (r_state)
        S_IDLE: if (st_sop) begin w_cap_x = 1'b1; w_nstate = S_HDRY; end
        S_HDRY: begin
          if (st_eop) begin
            w_cause_set[1] = 1'b1; w_err = 1'b1; w_nstate = S_IDLE;
          end else if (st_sop) begin
            w_cause_set[3] = 1'b1; w_err = 1'b1; w_cap_x = 1'b1;
          end else begin
            w_cap_y = 1'b1;
            if (!w_hdr_ok) begin
              w_cause_set[0] = 1'b1; w_err = 1'b1; w_nstate = S_DRAIN;
            end else begin
              w_pix_clr = 1'b1; w_nstate = S_PIX;
            end
          end
        end
        S_PIX: begin
          if (st_sop) begin
            // Mid-frame sop is the xres header of a new frame.
            w_cause_set[3] = 1'b1; w_err = 1'b1; w_cap_x = 1'b1; w_nstate = S_HDRY;
          end else begin
            w_pix_acc = 1'b1;
            if (st_eop) begin
              w_nstate = S_IDLE;
              if (w_last) w_good = 1'b1;
              else begin w_cause_set[1] = 1'b1; w_err = 1'b1; end
            end else if (w_last) begin
              w_cause_set[2] = 1'b1; w_err = 1'b1; w_nstate = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (st_sop)      begin w_cap_x = 1'b1; w_nstate = S_HDRY; end
          else if (st_eop) w_nstate = S_IDLE;
        end
        default: w_nstate = S_IDLE;
      endcase
    end
    // Protocol violation is flagged independently of framing.
    w_cause_set[4] = st_valid & ~r_rdy_d;
  end

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_frames <= '0; r_errors <= '0; r_cause <= '0; r_csum <= '0;
      r_sum    <= '0; r_cnt    <= '0; r_xres  <= '0; r_yres <= '0;
    end else begin
      if (w_cap_x) r_xres <= st_data;
      if (w_cap_y) r_yres <= st_data;
      if (w_pix_clr) begin
        r_sum <= '0; r_cnt <= '0;
      end else if (w_pix_acc) begin
        r_sum <= w_sum_n; r_cnt <= w_cnt_n;
      end
      if (w_clr) begin
        r_frames <= '0; r_errors <= '0; r_cause <= '0; r_csum <= '0;
      end else begin
        r_cause <= r_cause | w_cause_set;
        if (w_err) r_errors <= r_errors + 1'b1;
        if (w_good) begin
          r_frames <= r_frames + 1'b1;
          r_csum   <= w_sum_n;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_en <= 1'b0; r_thr <= '1; r_phase <= '0; r_ready <= 1'b0; r_rdy_d <= 1'b0;
    end else begin
      r_en    <= w_en_nxt;
      r_thr   <= w_thr_nxt;
      r_phase <= r_phase + 1'b1;
      r_ready <= w_en_nxt & w_thr_nxt[r_phase];
      r_rdy_d <= r_ready;
    end
  end

  always_comb begin
    w_rmux = '0;
    case (s_address)
      4'h0: w_rmux = {28'b0, |r_cause, (r_state != S_IDLE), 1'b0, r_en};
      4'h1: w_rmux = r_frames;
      4'h2: w_rmux = r_errors;
      4'h3: w_rmux = {16'(r_yres), 16'(r_xres)};
      4'h4: w_rmux = r_csum;
      4'h5: w_rmux = {27'b0, r_cause};
      4'h6: w_rmux = r_thr;
      default: w_rmux = '0;
    endcase
  end

  // Two-cycle reads: data registered in the first cycle, waitrequest drops in the second.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_rl <= 1'b0; r_rdata <= '0;
    end else begin
      r_rl <= s_read & ~r_rl;
      if (s_read && !r_rl) r_rdata <= w_rmux;
    end
  end
endmodule

// File: tb/tb_vga_stream_checker.sv
// Bench for vga_stream_checker with a reduced 6x3 frame. Expected register
// contents are derived per frame from the kind of frame sent.
module tb_vga_stream_checker;
  localparam int XR = 6, YR = 3, N = XR * YR, W = 16;

  logic clock = 1'b0, rst_n = 1'b0;
  logic [3:0] s_address = '0;
  logic [31:0] s_writedata = '0, s_readdata;
  logic s_read = 1'b0, s_write = 1'b0, s_waitrequest, st_ready;
  logic st_valid = 1'b0, st_sop = 1'b0, st_eop = 1'b0;
  logic [W-1:0] st_data = '0;

  int ncmp = 0, nfail = 0, ecnt = 0;
  logic [31:0] e_frames, e_errors, e_cause, e_csum, e_hdr, e_thr;
  logic e_en;

  vga_stream_checker #(.XRES(XR), .YRES(YR), .WIDTH(W)) dut (
    .clock(clock), .clock_areset_n(rst_n), .s_address(s_address),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .s_read(s_read),
    .s_write(s_write), .s_waitrequest(s_waitrequest), .st_ready(st_ready),
    .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop), .st_data(st_data));

  always #5 clock = ~clock;
  always @(posedge clock or negedge rst_n)
    if (!rst_n) ecnt <= 0; else ecnt <= ecnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic mm_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock); s_address = a; s_writedata = d; s_write = 1'b1;
    @(negedge clock); s_write = 1'b0;
  endtask

  task automatic mm_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clock); s_address = a; s_read = 1'b1;
    #1 chk("waitreq_hi", {31'b0, s_waitrequest}, 32'd1);
    @(negedge clock);
    chk("waitreq_lo", {31'b0, s_waitrequest}, 32'd0);
    d = s_readdata; s_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock); st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    end
  endtask

  // Compliant source: a beat is driven only in the cycle after st_ready was high.
  task automatic beat(input logic [W-1:0] d, input logic sop, input logic eop);
    int n = 0;
    while (!st_ready && n < 200) begin
      @(negedge clock); st_valid = 1'b0; n++;
    end
    if (n >= 200) begin
      ncmp++; nfail++;
      $display("FAIL ready_timeout obs=0 exp=1");
    end
    @(negedge clock); st_valid = 1'b1; st_sop = sop; st_eop = eop; st_data = d;
  endtask

  task automatic frame(input int xh, input int yh, input int npix, input bit eop_last,
                       output logic [31:0] sum);
    logic [W-1:0] px;
    sum = '0;
    beat(W'(xh), 1'b1, 1'b0);
    beat(W'(yh), 1'b0, 1'b0);
    for (int i = 1; i <= npix; i++) begin
      px = W'($urandom);
      sum = sum + 32'(px);
      beat(px, 1'b0, eop_last && (i == npix));
    end
    idle(1);
  endtask

  task automatic check_regs(input string tag, input bit busy);
    logic [31:0] d;
    mm_rd(4'h0, d); chk({tag, ".ctrl"}, d, {28'b0, |e_cause[4:0], busy, 1'b0, e_en});
    mm_rd(4'h1, d); chk({tag, ".frames"}, d, e_frames);
    mm_rd(4'h2, d); chk({tag, ".errors"}, d, e_errors);
    mm_rd(4'h3, d); chk({tag, ".hdr"}, d, e_hdr);
    mm_rd(4'h4, d); chk({tag, ".csum"}, d, e_csum);
    mm_rd(4'h5, d); chk({tag, ".cause"}, d, e_cause);
    mm_rd(4'h6, d); chk({tag, ".thr"}, d, e_thr);
  endtask

  task automatic model_reset();
    e_frames = 0; e_errors = 0; e_cause = 0; e_csum = 0; e_hdr = 0;
    e_thr = 32'hFFFF_FFFF; e_en = 1'b0;
  endtask

  initial begin
    logic [31:0] s, d;
    logic [31:0] hdr_good;
    int k;
    hdr_good = {16'(YR), 16'(XR)};
    model_reset();
    #13 chk("rst.st_ready", {31'b0, st_ready}, 32'd0);
    chk("rst.readdata", s_readdata, 32'd0);
    @(negedge clock); rst_n = 1'b1;
    check_regs("rst", 1'b0);
    mm_rd(4'h7, d); chk("rst.addr7", d, 32'd0);

    // Good frame
    mm_wr(4'h0, 32'h1); e_en = 1'b1;
    frame(XR, YR, N, 1, s);
    e_frames++; e_csum = s; e_hdr = hdr_good;
    check_regs("good", 1'b0);

    // Header mismatch then good frame
    frame(XR + 1, YR, N, 1, s);
    e_errors++; e_cause |= 32'h1; e_hdr = {16'(YR), 16'(XR + 1)};
    check_regs("hdrbad", 1'b0);
    frame(XR, YR, N, 1, s);
    e_frames++; e_csum = s; e_hdr = hdr_good;
    check_regs("good2", 1'b0);

    // Short frame
    k = $urandom_range(1, N - 1);
    frame(XR, YR, k, 1, s);
    e_errors++; e_cause |= 32'h2;
    check_regs("short", 1'b0);

    // Long frame: five extra beats, eop on the last
    frame(XR, YR, N + 5, 1, s);
    e_errors++; e_cause |= 32'h4;
    check_regs("long", 1'b0);

    // sop mid-frame, then a full good frame
    k = $urandom_range(1, N - 1);
    frame(XR, YR, k, 0, s);
    frame(XR, YR, N, 1, s);
    e_errors++; e_cause |= 32'h8; e_frames++; e_csum = s;
    check_regs("sopmid", 1'b0);

    // Throttle pattern: ready after edge k is THROTTLE[(k-1) mod 32]
    mm_wr(4'h6, 32'h5555_5555); e_thr = 32'h5555_5555;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("thr.ready", {31'b0, st_ready}, (e_thr >> ((ecnt - 1) % 32)) & 32'd1);
    end
    frame(XR, YR, N, 1, s);
    e_frames++; e_csum = s;
    check_regs("thrgood", 1'b0);

    // Beat while ready was low: only the protocol cause bit
    mm_wr(4'h6, 32'h0); e_thr = 32'h0;
    idle(2);
    @(negedge clock); st_valid = 1'b1; st_sop = 1'b0; st_eop = 1'b0; st_data = W'($urandom);
    idle(1);
    e_cause |= 32'h10;
    check_regs("b4", 1'b0);
    mm_wr(4'h6, 32'hFFFF_FFFF); e_thr = 32'hFFFF_FFFF;

    // Clear during PIX
    beat(W'(XR), 1'b1, 1'b0); beat(W'(YR), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) beat(W'($urandom), 1'b0, 1'b0);
    idle(1);
    check_regs("pix_busy", 1'b1);
    mm_wr(4'h0, 32'h3);
    e_frames = 0; e_errors = 0; e_cause = 0; e_csum = 0;
    check_regs("clear", 1'b0);

    // Async reset mid-frame
    frame(XR, YR, 5, 0, s);
    @(negedge clock); #2 rst_n = 1'b0;
    #1 chk("areset.st_ready", {31'b0, st_ready}, 32'd0);
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    @(negedge clock); rst_n = 1'b1;
    model_reset();
    check_regs("areset", 1'b0);
    mm_wr(4'h0, 32'h1); e_en = 1'b1;
    for (int i = 6; i <= N; i++) beat(W'($urandom), 1'b0, i == N);
    idle(1);
    frame(XR, YR, N, 1, s);
    e_frames++; e_csum = s; e_hdr = hdr_good;
    check_regs("resume", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
